// File: rtl/noc_flit_pkg.sv
// Shared flit definitions for the NoC: header marker position, body-length
// field, and the arbiter state encoding. Used by the packetizer, input Port
// logic and packet_output_arbiter.
package noc_flit_pkg;

    localparam int FLIT_W  = 8;           // default flit width
    localparam int HDR_BIT = FLIT_W - 1;  // header marker bit
    localparam int LEN_W   = 4;           // body-length field width
    localparam int LEN_LSB = 0;           // length field = header[LEN_W-1:LEN_LSB]
    localparam int LEN_MSB = LEN_LSB + LEN_W - 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BODY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin priority picker: returns the first requesting index at or
// above rr_ptr, wrapping modulo NUM_INPUTS. Purely combinational.
//   req     in   NUM_INPUTS      request vector
//   rr_ptr  in   LOG_NUM_INPUTS  highest-priority index this cycle
//   found   out  1               any request present
//   winner  out  LOG_NUM_INPUTS  selected index (rr_ptr when none found)
module rr_priority_picker #(
    parameter int NUM_INPUTS     = 4,
    parameter int LOG_NUM_INPUTS = 2
) (
    input  logic [NUM_INPUTS-1:0]     req,
    input  logic [LOG_NUM_INPUTS-1:0] rr_ptr,
    output logic                      found,
    output logic [LOG_NUM_INPUTS-1:0] winner
);

    logic [LOG_NUM_INPUTS-1:0] idx;

    // Scan from the farthest offset down to offset 0 so the closest
    // requester to rr_ptr is the last one written and therefore wins.
    always_comb begin
        found  = 1'b0;
        winner = rr_ptr;
        idx    = '0;
        for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
            idx = LOG_NUM_INPUTS'((int'(rr_ptr) + k) % NUM_INPUTS);
            if (req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/packet_output_arbiter.sv
// Wormhole round-robin arbiter between NUM_INPUTS input Port FIFOs and one
// output Port. A header flit wins arbitration, then its LEN body flits follow
// from the same input before priority rotates. The data path is
// combinational; only state, owner, body count and rr pointer are registered.
//   clk        in   1                      clock, rising edge
//   rst        in   1                      asynchronous active-low reset
//   in_data    in   NUM_INPUTS*WORD_WIDTH  head flit of each input Port
//   in_valid   in   NUM_INPUTS             input Port i not empty
//   in_pop     out  NUM_INPUTS             read_enable to input Port i (one-hot/zero)
//   out_ready  in   1                      output Port can accept a flit
//   out_data   out  WORD_WIDTH             flit to output Port
//   out_write  out  1                      output Port write_enable
//   busy       out  1                      packet body in progress
//   owner      out  LOG_NUM_INPUTS         granted input (valid when busy)
//   drop       out  1                      orphan body flit discarded
module packet_output_arbiter
    import noc_flit_pkg::*;
#(
    parameter int NUM_INPUTS     = 4,
    parameter int LOG_NUM_INPUTS = 2,
    parameter int WORD_WIDTH     = FLIT_W,
    parameter int LEN_WIDTH      = LEN_W
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_INPUTS*WORD_WIDTH-1:0] in_data,
    input  logic [NUM_INPUTS-1:0]            in_valid,
    output logic [NUM_INPUTS-1:0]            in_pop,
    input  logic                             out_ready,
    output logic [WORD_WIDTH-1:0]            out_data,
    output logic                             out_write,
    output logic                             busy,
    output logic [LOG_NUM_INPUTS-1:0]        owner,
    output logic                             drop
);

    logic [NUM_INPUTS-1:0][WORD_WIDTH-1:0] flits;
    logic [NUM_INPUTS-1:0]                 cand;
    logic                                  found;
    logic [LOG_NUM_INPUTS-1:0]             winner;
    logic [LOG_NUM_INPUTS-1:0]             rr_ptr, owner_q;
    logic [LEN_WIDTH-1:0]                  cnt, win_len;
    logic                                  hdr_xfer, body_xfer, orphan;
    arb_state_e                            state, state_nxt;

    function automatic logic [LOG_NUM_INPUTS-1:0] ptr_inc(input logic [LOG_NUM_INPUTS-1:0] p);
        return (int'(p) == NUM_INPUTS - 1) ? '0 : p + 1'b1;
    endfunction

    assign flits = in_data;

    always_comb begin
        for (int i = 0; i < NUM_INPUTS; i++)
            cand[i] = in_valid[i] & flits[i][WORD_WIDTH-1];
    end

    rr_priority_picker #(
        .NUM_INPUTS     (NUM_INPUTS),
        .LOG_NUM_INPUTS (LOG_NUM_INPUTS)
    ) u_pick (
        .req    (cand),
        .rr_ptr (rr_ptr),
        .found  (found),
        .winner (winner)
    );

    // An orphan is only considered when no header is waiting anywhere, and
    // only at rr_ptr; popping it advances the scan so it cannot wedge IDLE.
    always_comb begin
        win_len   = flits[winner][LEN_WIDTH-1:0];
        hdr_xfer  = (state == ST_IDLE) & out_ready & found;
        orphan    = (state == ST_IDLE) & out_ready & ~found & in_valid[rr_ptr];
        body_xfer = (state == ST_BODY) & out_ready & in_valid[owner_q];
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // Next state
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (hdr_xfer && win_len != '0) state_nxt = ST_BODY;
            ST_BODY: if (body_xfer && cnt == LEN_WIDTH'(1)) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs; gated by rst so nothing moves while reset is held even though
    // the IDLE decode would otherwise see candidates.
    always_comb begin
        in_pop    = '0;
        out_write = 1'b0;
        out_data  = '0;
        drop      = 1'b0;
        if (rst) begin
            if (hdr_xfer) begin
                in_pop[winner] = 1'b1;
                out_write      = 1'b1;
                out_data       = flits[winner];
            end else if (orphan) begin
                in_pop[rr_ptr] = 1'b1;
                drop           = 1'b1;
                out_data       = flits[rr_ptr];
            end else if (body_xfer) begin
                in_pop[owner_q] = 1'b1;
                out_write       = 1'b1;
                out_data        = flits[owner_q];
            end
        end
    end

    assign busy  = (state == ST_BODY);
    assign owner = owner_q;

    // Arbitration bookkeeping. Header-only packets rotate priority at once;
    // longer packets rotate when their last body flit moves.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr  <= '0;
            owner_q <= '0;
            cnt     <= '0;
        end else if (hdr_xfer) begin
            if (win_len == '0) begin
                rr_ptr <= ptr_inc(winner);
            end else begin
                owner_q <= winner;
                cnt     <= win_len;
            end
        end else if (orphan) begin
            rr_ptr <= ptr_inc(rr_ptr);
        end else if (body_xfer) begin
            cnt <= cnt - 1'b1;
            if (cnt == LEN_WIDTH'(1)) rr_ptr <= ptr_inc(owner_q);
        end
    end

endmodule

// File: tb/tb_packet_output_arbiter.sv
// Bench for packet_output_arbiter: the input Port FIFOs are modelled as
// queues, and a packet-level model (who may send next, how many body flits
// remain) predicts every output each cycle. Literal expectations on the
// forwarded order pin the model for each directed scenario.
module tb_packet_output_arbiter;

    localparam int N  = 4;
    localparam int LN = 2;
    localparam int WW = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [N*WW-1:0]   in_data;
    logic [N-1:0]      in_valid;
    logic [N-1:0]      in_pop;
    logic              out_ready;
    logic [WW-1:0]     out_data;
    logic              out_write;
    logic              busy;
    logic [LN-1:0]     owner;
    logic              drop;

    always #5 clk = ~clk;

    packet_output_arbiter #(
        .NUM_INPUTS(N), .LOG_NUM_INPUTS(LN), .WORD_WIDTH(WW), .LEN_WIDTH(4)
    ) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_pop(in_pop), .out_ready(out_ready), .out_data(out_data),
        .out_write(out_write), .busy(busy), .owner(owner), .drop(drop)
    );

    logic [WW-1:0] q[N][$];
    int  m_rr, m_owner, m_rem;
    bit  m_busy;
    int  errors = 0, checks = 0;
    int  sent_data[$];
    int  sent_src[$];
    int  busy_cycles, drops;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_seq(input string name, input int act[$], input int exp[$]);
        chk({name, "_len"}, act.size(), exp.size());
        for (int i = 0; i < exp.size() && i < act.size(); i++)
            chk(name, act[i], exp[i]);
    endtask

    task automatic model_reset();
        m_busy = 0; m_rr = 0; m_owner = 0; m_rem = 0;
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            in_valid[i]         = (q[i].size() > 0);
            in_data[i*WW +: WW] = (q[i].size() > 0) ? q[i][0] : '0;
        end
    endtask

    // One clock: drive at negedge, predict and compare, then advance the
    // FIFOs and the model at the posedge. Returns at the next negedge.
    task automatic cycle();
        int pick, idx, len;
        bit wr, dr;
        logic [WW-1:0] d;
        logic [N-1:0]  exp_pop;
        drive_inputs();
        #1;
        pick = -1; wr = 0; dr = 0; d = '0;
        if (rst) begin
            if (!m_busy) begin
                if (out_ready) begin
                    for (int k = 0; k < N; k++) begin
                        idx = (m_rr + k) % N;
                        if (pick < 0 && q[idx].size() > 0 && q[idx][0][WW-1]) pick = idx;
                    end
                    if (pick >= 0) wr = 1;
                    else if (q[m_rr].size() > 0) begin pick = m_rr; dr = 1; end
                end
            end else if (out_ready && q[m_owner].size() > 0) begin
                pick = m_owner; wr = 1;
            end
        end
        if (pick >= 0) d = q[pick][0];
        exp_pop = '0;
        if (pick >= 0) exp_pop[pick] = 1'b1;
        chk("in_pop", 32'(in_pop), 32'(exp_pop));
        chk("out_write", 32'(out_write), 32'(wr));
        chk("out_data", 32'(out_data), 32'(d));
        chk("drop", 32'(drop), 32'(dr));
        chk("busy", 32'(busy), 32'(m_busy));
        if (m_busy) chk("owner", 32'(owner), 32'(m_owner));
        if (busy) busy_cycles++;
        if (drop) drops++;
        @(posedge clk);
        if (pick >= 0) begin
            void'(q[pick].pop_front());
            if (wr) begin sent_data.push_back(int'(d)); sent_src.push_back(pick); end
            if (dr) begin
                m_rr = (m_rr + 1) % N;
            end else if (!m_busy) begin
                len = int'(d[3:0]);
                if (len == 0) m_rr = (pick + 1) % N;
                else begin m_busy = 1; m_owner = pick; m_rem = len; end
            end else begin
                m_rem--;
                if (m_rem == 0) begin m_busy = 0; m_rr = (m_owner + 1) % N; end
            end
        end
        @(negedge clk);
    endtask

    task automatic run_until_idle(input int max, output int n);
        bit pending;
        n = 0;
        do begin
            pending = m_busy;
            for (int i = 0; i < N; i++) if (q[i].size() > 0) pending = 1;
            if (pending && n < max) begin cycle(); n++; end
        end while (pending && n < max);
        if (pending) chk("idle_timeout", 32'(n), 32'(max + 1));
    endtask

    task automatic clear_log();
        sent_data.delete(); sent_src.delete(); busy_cycles = 0; drops = 0;
    endtask

    initial begin
        int n;
        int e[$];
        out_ready = 1'b1;
        model_reset();
        clear_log();
        for (int i = 0; i < N; i++) q[i].push_back(8'h80);
        drive_inputs();
        @(negedge clk);

        // 1: held in reset with every input offering a header
        cycle(); cycle();
        chk("t1_sent_in_reset", 32'(sent_src.size()), 0);
        rst = 1'b1;
        run_until_idle(20, n);
        e = '{0, 1, 2, 3}; chk_seq("t1_order_from_0", sent_src, e);

        // 2: single 3-flit packet from input 1
        clear_log();
        q[1].push_back(8'h82); q[1].push_back(8'hA1); q[1].push_back(8'hA2);
        run_until_idle(20, n);
        chk("t2_cycles", 32'(n), 3);
        e = '{'h82, 'hA1, 'hA2}; chk_seq("t2_data", sent_data, e);
        chk("t2_busy_cycles", 32'(busy_cycles), 2);

        // 3: rr at 2 -> input0 alone moves rr to 1, then 2 beats 0
        clear_log();
        q[0].push_back(8'h80);
        run_until_idle(10, n);
        q[0].push_back(8'h80); q[2].push_back(8'h80);
        run_until_idle(10, n);
        chk("t3_cycles", 32'(n), 2);
        e = '{0, 2, 0}; chk_seq("t3_order", sent_src, e);

        // 4: wormhole lock while owner runs dry
        clear_log();
        q[0].push_back(8'h83);
        cycle();
        q[3].push_back(8'h80);
        cycle(); cycle(); cycle();
        chk("t4_in3_waiting", 32'(q[3].size()), 1);
        q[0].push_back(8'h31); q[0].push_back(8'h32); q[0].push_back(8'h33);
        run_until_idle(20, n);
        e = '{0, 0, 0, 0, 3}; chk_seq("t4_order", sent_src, e);
        e = '{'h83, 'h31, 'h32, 'h33, 'h80}; chk_seq("t4_data", sent_data, e);

        // 5: backpressure mid-body
        clear_log();
        q[1].push_back(8'h83); q[1].push_back(8'h41);
        q[1].push_back(8'h42); q[1].push_back(8'h43);
        cycle(); cycle();
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) cycle();
        chk("t5_held_count", 32'(sent_data.size()), 2);
        out_ready = 1'b1;
        run_until_idle(20, n);
        e = '{'h83, 'h41, 'h42, 'h43}; chk_seq("t5_data", sent_data, e);

        // 6a: reset mid-body, then re-arbitration restarts at input 0
        clear_log();
        q[2].push_back(8'h85);
        for (int k = 0; k < 5; k++) q[2].push_back(WW'(8'h12 + k));
        cycle(); cycle();
        chk("t6_busy_before_rst", 32'(busy), 1);
        rst = 1'b0;
        model_reset();
        cycle();
        rst = 1'b1;
        q[2].delete();
        clear_log();
        q[0].push_back(8'h80); q[3].push_back(8'h80);
        run_until_idle(10, n);
        e = '{0, 3}; chk_seq("t6_order_after_rst", sent_src, e);

        // 6b: orphan body flit at rr_ptr=0 is dropped, not forwarded
        clear_log();
        q[0].push_back(8'h05);
        run_until_idle(10, n);
        chk("t6_drops", 32'(drops), 1);
        chk("t6_orphan_sent", 32'(sent_data.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
